// File: rtl/debounce_sched_pkg.sv
// rtl/debounce_sched_pkg.sv - width helpers and parameter legality checks for debounce_scheduler
package debounce_sched_pkg;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_DEBOUNCE_LIMIT = 20;
    localparam int DEF_SCAN_DIV       = 1;

    // Channel index width; never narrower than one bit
    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Per-channel count width; holds 0..limit-1
    function automatic int calc_cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    // Prescaler width; a divide-by-one prescaler still gets one bit
    function automatic int calc_div_w(input int scan_div);
        return (scan_div > 1) ? $clog2(scan_div) : 1;
    endfunction

    function automatic bit params_legal(input int num_ch, input int limit, input int scan_div);
        return (num_ch >= 2) && (limit >= 2) && (scan_div >= 1);
    endfunction

    localparam int CH_W  = calc_ch_w(DEF_NUM_CH);
    localparam int CNT_W = calc_cnt_w(DEF_DEBOUNCE_LIMIT);

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - scan prescaler and round-robin channel pointer
module scan_tick_gen
    import debounce_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SCAN_DIV = 1,
    localparam int PTR_W   = calc_ch_w(NUM_CH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             tick_o,
    output logic [PTR_W-1:0] ptr_o
);

    localparam int               DIV_W    = calc_div_w(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [PTR_W-1:0] ptr_q;

    assign tick_o = (div_cnt_q == DIV_LAST);
    assign ptr_o  = ptr_q;

    // Prescaler wraps on each tick; the pointer steps one channel per tick
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            ptr_q     <= '0;
        end else if (tick_o) begin
            div_cnt_q <= '0;
            ptr_q     <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - time-shared debounce engine over NUM_CH inputs; DEBOUNCE_SCHED_SYNC_EN adds 2-flop input synchronizers
module debounce_scheduler
    import debounce_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 20,
    parameter int SCAN_DIV       = 1,
    localparam int CH_BITS       = calc_ch_w(NUM_CH)
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic [NUM_CH-1:0]  i_Bouncy,
    output logic [NUM_CH-1:0]  o_Debounced,
    output logic               o_Changed,
    output logic [CH_BITS-1:0] o_Changed_Ch
);

    localparam int                  CNT_BITS = calc_cnt_w(DEBOUNCE_LIMIT);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_LIMIT - 1);

    if (!params_legal(NUM_CH, DEBOUNCE_LIMIT, SCAN_DIV)) begin : g_bad_params
        $error("debounce_scheduler: NUM_CH>=2, DEBOUNCE_LIMIT>=2, SCAN_DIV>=1 required");
    end

    logic               tick;
    logic [CH_BITS-1:0] ptr;
    logic [NUM_CH-1:0]  sample;

    scan_tick_gen #(
        .NUM_CH   (NUM_CH),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick_gen (
        .clk_i  (i_Clk),
        .rst_ni (i_Rst_L),
        .tick_o (tick),
        .ptr_o  (ptr)
    );

`ifdef DEBOUNCE_SCHED_SYNC_EN
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    // Two-flop synchronizer on every raw input bit
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_Bouncy;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = i_Bouncy;
`endif

    logic [CNT_BITS-1:0] cnt_q [NUM_CH];
    logic [NUM_CH-1:0]   stable_q;
    logic                changed_q;
    logic [CH_BITS-1:0]  changed_ch_q;

    logic                s_cur;
    logic                stable_cur;
    logic [CNT_BITS-1:0] cnt_cur;
    logic [CNT_BITS-1:0] cnt_d;
    logic                flip_d;

    // Shared engine: compare the visited channel's sample to its stable level
    always_comb begin
        s_cur      = sample[ptr];
        stable_cur = stable_q[ptr];
        cnt_cur    = cnt_q[ptr];
        flip_d     = 1'b0;
        cnt_d      = cnt_cur;
        if (s_cur == stable_cur) begin
            cnt_d = '0;
        end else if (cnt_cur == CNT_LAST) begin
            flip_d = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_cur + 1'b1;
        end
    end

    // Write back the visited channel; change pulse lasts one clock
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
            stable_q     <= '0;
            changed_q    <= 1'b0;
            changed_ch_q <= '0;
        end else begin
            changed_q    <= 1'b0;
            changed_ch_q <= '0;
            if (tick) begin
                cnt_q[ptr] <= cnt_d;
                if (flip_d) begin
                    stable_q[ptr] <= s_cur;
                    changed_q     <= 1'b1;
                    changed_ch_q  <= ptr;
                end
            end
        end
    end

    assign o_Debounced  = stable_q;
    assign o_Changed    = changed_q;
    assign o_Changed_Ch = changed_ch_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - randomized self-checking bench for debounce_scheduler
module tb_debounce_scheduler;

    localparam int NCH = 4;
    localparam int LIM = 4;
`ifdef DEBOUNCE_SCHED_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_l;
    logic [3:0] bouncy_a;
    logic [3:0] bouncy_b;
    logic [3:0] deb_a;
    logic [3:0] deb_b;
    logic       chg_a;
    logic       chg_b;
    logic [1:0] ch_a;
    logic [1:0] ch_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_scheduler #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(LIM), .SCAN_DIV(1)) dut_a (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Bouncy     (bouncy_a),
        .o_Debounced  (deb_a),
        .o_Changed    (chg_a),
        .o_Changed_Ch (ch_a)
    );

    debounce_scheduler #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(LIM), .SCAN_DIV(3)) dut_b (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Bouncy     (bouncy_b),
        .o_Debounced  (deb_b),
        .o_Changed    (chg_b),
        .o_Changed_Ch (ch_b)
    );

    // Reference for dut_a: the n-th clock after reset visits channel n mod NCH;
    // a channel flips after LIM consecutive visits that disagree with it.
    bit [3:0] m_deb;
    bit       m_chg;
    int       m_ch;
    int       m_visits;
    int       m_run [NCH];
    bit [3:0] m_s1;
    bit [3:0] m_s2;

    always @(posedge clk) begin : model
        bit [3:0] s;
        int p;
        if (!rst_l) begin
            m_deb = '0; m_chg = 0; m_ch = 0; m_visits = 0;
            m_s1 = '0; m_s2 = '0;
            for (int k = 0; k < NCH; k++) m_run[k] = 0;
        end else begin
            s = (SYNC_LAT > 0) ? m_s2 : bouncy_a;
            m_s2 = m_s1;
            m_s1 = bouncy_a;
            p = m_visits % NCH;
            m_visits++;
            m_chg = 0;
            m_ch = 0;
            if (s[p] != m_deb[p]) begin
                m_run[p]++;
                if (m_run[p] == LIM) begin
                    m_deb[p] = s[p];
                    m_run[p] = 0;
                    m_chg = 1;
                    m_ch = p;
                end
            end else begin
                m_run[p] = 0;
            end
        end
    end

    task automatic do_reset(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst_l = 1'b0;
        bouncy_a = a;
        bouncy_b = b;
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        bouncy_a = 4'hF;
        bouncy_b = 4'hF;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (deb_a !== 4'h0 || chg_a !== 1'b0 || ch_a !== 2'd0) begin
                errors++;
                $display("FAIL reset_a deb=%h chg=%b ch=%0d required deb=0 chg=0 ch=0", deb_a, chg_a, ch_a);
            end
            checks++;
            if (deb_b !== 4'h0 || chg_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_b deb=%h chg=%b required deb=0 chg=0", deb_b, chg_b);
            end
        end
        bouncy_a = 4'h0;
        bouncy_b = 4'h0;
        rst_l = 1'b1;
    endtask

    task automatic test_clean_rise();
        int lat = 0;
        int pulses = 0;
        do_reset(4'h0, 4'h0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bouncy_a[0] = 1'b1;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (chg_a === 1'b1) begin
                pulses++;
                checks++;
                if (ch_a !== 2'd0) begin
                    errors++;
                    $display("FAIL rise_ch ch=%0d required 0", ch_a);
                end
            end
            checks++;
            if (deb_a !== m_deb || chg_a !== m_chg) begin
                errors++;
                $display("FAIL rise_model deb=%h chg=%b required deb=%h chg=%b", deb_a, chg_a, m_deb, m_chg);
            end
            if (deb_a[0] === 1'b1) lat = i;
        end
        checks++;
        if (lat < 13 + SYNC_LAT || lat > 16 + SYNC_LAT) begin
            errors++;
            $display("FAIL rise_latency clocks=%0d required %0d..%0d", lat, 13 + SYNC_LAT, 16 + SYNC_LAT);
        end
        repeat (12) begin
            @(negedge clk);
            if (chg_a === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL rise_pulses count=%0d required 1", pulses);
        end
        checks++;
        if (deb_a !== 4'h1) begin
            errors++;
            $display("FAIL rise_others deb=%h required 1", deb_a);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        bouncy_a[2] = 1'b1;
        repeat (5) @(negedge clk);
        bouncy_a[2] = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (chg_a === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || deb_a[2] !== 1'b0) begin
            errors++;
            $display("FAIL glitch pulses=%0d deb2=%b required pulses=0 deb2=0", pulses, deb_a[2]);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int t [4];
        int c [4];
        bouncy_a[1] = 1'b1;
        bouncy_a[3] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (chg_a === 1'b1 && n < 4) begin
                t[n] = i;
                c[n] = int'(ch_a);
                n++;
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL simul_count pulses=%0d required 2", n);
        end else begin
            checks++;
            if (c[0] != 1 || c[1] != 3 || t[1] - t[0] != 2) begin
                errors++;
                $display("FAIL simul_order ch=%0d,%0d gap=%0d required ch=1,3 gap=2", c[0], c[1], t[1] - t[0]);
            end
        end
        checks++;
        if (deb_a !== 4'hB) begin
            errors++;
            $display("FAIL simul_level deb=%h required b", deb_a);
        end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        do_reset(4'h1, 4'h0);
        repeat (10) @(negedge clk);
        checks++;
        if (deb_a !== 4'h0) begin
            errors++;
            $display("FAIL midreset_pre deb=%h required 0", deb_a);
        end
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(negedge clk);
            checks++;
            if (deb_a !== m_deb || chg_a !== m_chg) begin
                errors++;
                $display("FAIL midreset_model deb=%h chg=%b required deb=%h chg=%b", deb_a, chg_a, m_deb, m_chg);
            end
            if (deb_a[0] === 1'b1) lat = i;
        end
        checks++;
        if (lat < 13 || lat > 13 + SYNC_LAT + 4) begin
            errors++;
            $display("FAIL midreset_latency clocks=%0d required %0d..%0d", lat, 13, 17 + SYNC_LAT);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset(4'h0, 4'h0);
        for (int phase = 0; phase < 30; phase++) begin
            int rate = $urandom_range(2, 40);
            if (phase == 15) begin
                rst_l = 1'b0;
                @(negedge clk);
                rst_l = 1'b1;
            end
            repeat (60) begin
                @(negedge clk);
                checks++;
                if (deb_a !== m_deb || chg_a !== m_chg || ch_a !== m_ch[1:0]) begin
                    errors++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL random deb=%h chg=%b ch=%0d required deb=%h chg=%b ch=%0d",
                                 deb_a, chg_a, ch_a, m_deb, m_chg, m_ch);
                    end
                end
                for (int k = 0; k < NCH; k++) begin
                    if ($urandom_range(0, rate - 1) == 0) bouncy_a[k] = ~bouncy_a[k];
                end
            end
        end
    endtask

    task automatic test_div3();
        int lat = 0;
        int pulses = 0;
        do_reset(4'h0, 4'h0);
        repeat ($urandom_range(0, 11)) @(negedge clk);
        bouncy_b[0] = 1'b1;
        for (int i = 1; i <= 80 && lat == 0; i++) begin
            @(negedge clk);
            if (chg_b === 1'b1) begin
                pulses++;
                checks++;
                if (ch_b !== 2'd0) begin
                    errors++;
                    $display("FAIL div3_ch ch=%0d required 0", ch_b);
                end
            end
            if (deb_b[0] === 1'b1) lat = i;
        end
        checks++;
        if (lat < 37 + SYNC_LAT || lat > 48 + SYNC_LAT) begin
            errors++;
            $display("FAIL div3_latency clocks=%0d required %0d..%0d", lat, 37 + SYNC_LAT, 48 + SYNC_LAT);
        end
        repeat (30) begin
            @(negedge clk);
            if (chg_b === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || deb_b !== 4'h1) begin
            errors++;
            $display("FAIL div3_pulses count=%0d deb=%h required count=1 deb=1", pulses, deb_b);
        end
    endtask

    initial begin
        rst_l = 1'b0;
        bouncy_a = 4'hF;
        bouncy_b = 4'hF;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_div3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
